// File: rtl/firing_sequencer.sv
// Firing-datapath sequencer: one SHOT per trigger press, a settle cycle, cooldown after a miss,
// and a timed reload at round end. Optional ARMED idle timeout enabled by FIRE_TIMEOUT_EN.
module firing_sequencer #(
    parameter int CNT_W           = 16,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int RELOAD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       round_start,
    input  logic [1:0] remaining_shots,
    input  logic       is_shot,
    input  logic       fall,
    output logic [2:0] control,
    output logic       shot_fired,
    output logic       round_hit,
    output logic       round_done,
    output logic       timeout
);

    // state    | meaning
    // IDLE     | round over, waiting for round_start
    // ARMED    | waiting for a trigger press
    // FIRE     | single SHOT cycle
    // SETTLE   | datapath results valid, decide next step
    // COOLDOWN | hold after a miss before the next shot
    // RELOAD   | timed reload at round end
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        FIRE     = 3'd2,
        SETTLE   = 3'd3,
        COOLDOWN = 3'd4,
        RELOAD   = 3'd5
    } state_t;

    localparam logic [2:0] CTRL_RELOAD = 3'b000;
    localparam logic [2:0] CTRL_HOLD   = 3'b001;
    localparam logic [2:0] CTRL_SHOT   = 3'b011;

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(RELOAD_CYCLES - 1);
`ifdef FIRE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q, trig_d;
    logic             round_hit_q, round_hit_d;
    logic             fire_req;
    logic             fire_ok;
    logic             done_pulse;
    logic             to_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            round_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            round_hit_q <= round_hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_d      = trigger;
        round_hit_d = round_hit_q;
        done_pulse  = 1'b0;
        to_pulse    = 1'b0;
        fire_req    = trigger & ~trig_q;
        fire_ok     = fire_req & ~fall;

        case (state_q)
            IDLE: begin
                if (round_start) begin
                    state_d     = ARMED;
                    round_hit_d = 1'b0;
`ifdef FIRE_TIMEOUT_EN
                    cnt_d       = TO_LOAD;
`endif
                end
            end
            ARMED: begin
                if (fire_ok) begin
                    state_d = FIRE;
                end
`ifdef FIRE_TIMEOUT_EN
                // an accepted press in the expiry cycle takes priority over the timeout
                else if (cnt_q == '0) begin
                    state_d     = RELOAD;
                    round_hit_d = 1'b0;
                    cnt_d       = RL_LOAD;
                    to_pulse    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            FIRE: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (is_shot) begin
                    state_d     = RELOAD;
                    round_hit_d = 1'b1;
                    cnt_d       = RL_LOAD;
                end else if (remaining_shots == 2'd0) begin
                    state_d     = RELOAD;
                    round_hit_d = 1'b0;
                    cnt_d       = RL_LOAD;
                end else begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) begin
                    state_d = ARMED;
`ifdef FIRE_TIMEOUT_EN
                    cnt_d   = TO_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELOAD: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    done_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // control decodes the registered state, so it moves on the edge entering each state
    always_comb begin
        control = CTRL_RELOAD;
        case (state_q)
            ARMED, SETTLE, COOLDOWN: control = CTRL_HOLD;
            FIRE:                    control = CTRL_SHOT;
            default:                 control = CTRL_RELOAD;
        endcase
    end

    assign shot_fired = (state_q == FIRE);
    assign round_hit  = round_hit_q;
    assign round_done = done_pulse;
    assign timeout    = to_pulse;

endmodule

// File: tb/tb_firing_sequencer.sv
// Directed self-checking bench for firing_sequencer; timeout scenario runs when FIRE_TIMEOUT_EN is defined.
module tb_firing_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       round_start;
    logic [1:0] remaining_shots;
    logic       is_shot;
    logic       fall;
    logic [2:0] control;
    logic       shot_fired;
    logic       round_hit;
    logic       round_done;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    firing_sequencer #(
        .CNT_W          (16),
        .COOLDOWN_CYCLES(4),
        .RELOAD_CYCLES  (8),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trigger        (trigger),
        .round_start    (round_start),
        .remaining_shots(remaining_shots),
        .is_shot        (is_shot),
        .fall           (fall),
        .control        (control),
        .shot_fired     (shot_fired),
        .round_hit      (round_hit),
        .round_done     (round_done),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // eight RELOAD cycles, round_done only on the last; round_start there must be ignored
    task automatic reload_phase(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_ctrl"}, 8'(control), 8'h0);
            chk({tag, "_done"}, 8'(round_done), (i == 7) ? 8'h1 : 8'h0);
            if (i == 7) round_start = 1'b1;
            step();
        end
        round_start = 1'b0;
        chk({tag, "_idle_ctrl"}, 8'(control), 8'h0);
        chk({tag, "_idle_done"}, 8'(round_done), 8'h0);
        step();
        chk({tag, "_start_ignored"}, 8'(control), 8'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        trigger         = 1'b0;
        round_start     = 1'b0;
        remaining_shots = 2'd2;
        is_shot         = 1'b0;
        fall            = 1'b0;
        #12;
        chk("rst_ctrl", 8'(control), 8'h0);
        chk("rst_shot", 8'(shot_fired), 8'h0);
        chk("rst_hit", 8'(round_hit), 8'h0);
        chk("rst_done", 8'(round_done), 8'h0);
        chk("rst_to", 8'(timeout), 8'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_ctrl", 8'(control), 8'h0);

`ifndef FIRE_TIMEOUT_EN
        // round A: single hit
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        chk("a_armed", 8'(control), 8'h1);
        trigger = 1'b1;
        step();
        chk("a_fire_ctrl", 8'(control), 8'h3);
        chk("a_fire_pulse", 8'(shot_fired), 8'h1);
        trigger = 1'b0;
        is_shot = 1'b1;
        step();
        chk("a_settle", 8'(control), 8'h1);
        chk("a_settle_pulse", 8'(shot_fired), 8'h0);
        step();
        is_shot = 1'b0;
        chk("a_hit", 8'(round_hit), 8'h1);
        reload_phase("a_rl");
        chk("a_hit_hold", 8'(round_hit), 8'h1);

        // round B: three misses with remaining 2,1,0
        remaining_shots = 2'd2;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        chk("b_armed", 8'(control), 8'h1);
        chk("b_hit_clr", 8'(round_hit), 8'h0);
        trigger = 1'b1;
        step();
        chk("b1_fire", 8'(control), 8'h3);
        step();
        chk("b1_settle", 8'(control), 8'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b1_cooldown", 8'(control), 8'h1);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            chk("held_ctrl", 8'(control), 8'h1);
            chk("held_pulse", 8'(shot_fired), 8'h0);
            chk("held_to", 8'(timeout), 8'h0);
        end
        trigger = 1'b0;
        step();
        fall    = 1'b1;
        trigger = 1'b1;
        step();
        chk("fall_no_shot", 8'(control), 8'h1);
        step();
        chk("fall_no_shot2", 8'(control), 8'h1);
        trigger = 1'b0;
        fall    = 1'b0;
        step();

        remaining_shots = 2'd1;
        trigger = 1'b1;
        step();
        chk("b2_fire", 8'(control), 8'h3);
        trigger = 1'b0;
        step();
        step();
        step();
        step();
        step();
        trigger = 1'b1;
        step();
        chk("cd_edge_dropped", 8'(control), 8'h1);
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        chk("b3_fire", 8'(control), 8'h3);
        chk("b3_pulse", 8'(shot_fired), 8'h1);
        trigger = 1'b0;
        remaining_shots = 2'd0;
        step();
        chk("b3_settle", 8'(control), 8'h1);
        step();
        chk("b3_hit", 8'(round_hit), 8'h0);
        reload_phase("b_rl");

        // round C: reset in the middle of cooldown
        remaining_shots = 2'd2;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        trigger = 1'b1;
        step();
        chk("c_fire", 8'(control), 8'h3);
        trigger = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("c_rst_ctrl", 8'(control), 8'h0);
        chk("c_rst_hit", 8'(round_hit), 8'h0);
        @(negedge clk);
        reset   = 1'b0;
        trigger = 1'b1;
        step();
        chk("c_no_rearm", 8'(control), 8'h0);
        step();
        chk("c_no_rearm2", 8'(control), 8'h0);
        trigger = 1'b0;
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        chk("c_rearm", 8'(control), 8'h1);
`else
        // timeout with no trigger: pulse in the 10th ARMED cycle
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("to_ctrl", 8'(control), 8'h1);
            chk("to_pulse", 8'(timeout), (i == 9) ? 8'h1 : 8'h0);
            step();
        end
        chk("to_reload", 8'(control), 8'h0);
        chk("to_hit", 8'(round_hit), 8'h0);
        chk("to_pulse_gone", 8'(timeout), 8'h0);
        reload_phase("to_rl");

        // trigger rise in the expiry cycle wins
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        trigger = 1'b1;
        #1;
        chk("exp_no_to", 8'(timeout), 8'h0);
        step();
        trigger = 1'b0;
        chk("exp_fire", 8'(control), 8'h3);
        chk("exp_pulse", 8'(shot_fired), 8'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
